// File: rtl/crc_attach_bus.sv
// Appends a CRC-24A to each of eight independent serial bit-streams and frames
// the resulting block (payload followed by CRC) onto the interleaver bus.
module crc_attach_bus (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       blocksize_sel,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       CRC_start,
  output logic       CRC_blocksize,
  output logic       CRC_end,
  output logic       error,
  output logic [1:0] fsm_state
);

  // Handshake: a word transfers on a rising edge where data_valid && in_ready.
  // Once a block has started, data_valid must stay high for every payload word;
  // a low data_valid during the payload aborts the block (error pulse).
  // in_ready is low for the 24 CRC cycles and during reset.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CRC     = 2'd2
  } state_t;

  localparam logic [23:0] POLY      = 24'h864CFB;
  localparam logic [12:0] LEN_SMALL = 13'd1032;
  localparam logic [12:0] LEN_LARGE = 13'd6120;

  state_t          state, state_nx;
  logic [12:0]     cnt, cnt_nx;
  logic [4:0]      crc_idx, crc_idx_nx;
  logic [7:0][23:0] lfsr, lfsr_nx;
  logic [12:0]     limit;
  logic            accept;
  logic            last_payload;

  logic [7:0]      data_nx;
  logic            start_nx;
  logic            end_nx;
  logic            err_nx;
  logic            bsz_nx;
  logic            rdy_nx;

  // Serial CRC-24A step, data entering at the MSB end (non-reflected).
  function automatic logic [23:0] crc_step(input logic [23:0] r, input logic d);
    logic fb;
    fb = r[23] ^ d;
    return {r[22:0], 1'b0} ^ (fb ? POLY : 24'h000000);
  endfunction

  assign limit        = CRC_blocksize ? LEN_LARGE : LEN_SMALL;
  assign accept       = data_valid && in_ready;
  assign last_payload = ((cnt + 13'd1) == limit);
  assign fsm_state    = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!data_valid)       state_nx = S_IDLE;
        else if (last_payload) state_nx = S_CRC;
      end
      S_CRC: begin
        if (crc_idx == 5'd23) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything is registered below
  always_comb begin
    cnt_nx     = cnt;
    crc_idx_nx = crc_idx;
    lfsr_nx    = lfsr;
    data_nx    = 8'h00;
    start_nx   = 1'b0;
    end_nx     = 1'b0;
    err_nx     = 1'b0;
    bsz_nx     = CRC_blocksize;
    rdy_nx     = (state_nx != S_CRC);
    case (state)
      S_IDLE: begin
        if (accept) begin
          bsz_nx   = blocksize_sel;
          data_nx  = data_in;
          start_nx = 1'b1;
          cnt_nx   = 13'd1;
          for (int i = 0; i < 8; i++) lfsr_nx[i] = crc_step(lfsr[i], data_in[i]);
        end
      end
      S_PAYLOAD: begin
        if (data_valid) begin
          data_nx    = data_in;
          cnt_nx     = cnt + 13'd1;
          crc_idx_nx = 5'd0;
          for (int i = 0; i < 8; i++) lfsr_nx[i] = crc_step(lfsr[i], data_in[i]);
        end else begin
          err_nx  = 1'b1;
          cnt_nx  = 13'd0;
          lfsr_nx = '0;
        end
      end
      S_CRC: begin
        // Remainder shifts out MSB first with no feedback.
        for (int i = 0; i < 8; i++) begin
          data_nx[i] = lfsr[i][23];
          lfsr_nx[i] = {lfsr[i][22:0], 1'b0};
        end
        crc_idx_nx = crc_idx + 5'd1;
        if (crc_idx == 5'd23) begin
          end_nx     = 1'b1;
          crc_idx_nx = 5'd0;
          cnt_nx     = 13'd0;
          lfsr_nx    = '0;
        end
      end
      default: begin
        cnt_nx     = 13'd0;
        crc_idx_nx = 5'd0;
        lfsr_nx    = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= 13'd0;
      crc_idx       <= 5'd0;
      lfsr          <= '0;
      data_out      <= 8'h00;
      CRC_start     <= 1'b0;
      CRC_end       <= 1'b0;
      error         <= 1'b0;
      CRC_blocksize <= 1'b0;
      in_ready      <= 1'b0;
    end else begin
      cnt           <= cnt_nx;
      crc_idx       <= crc_idx_nx;
      lfsr          <= lfsr_nx;
      data_out      <= data_nx;
      CRC_start     <= start_nx;
      CRC_end       <= end_nx;
      error         <= err_nx;
      CRC_blocksize <= bsz_nx;
      in_ready      <= rdy_nx;
    end
  end

endmodule

// File: tb/tb_crc_attach_bus.sv
// Directed bench for crc_attach_bus: table of sparse payload patterns with
// hand-reduced CRC-24A remainders, plus abort and mid-block reset sequences.
module tb_crc_attach_bus;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       blocksize_sel;
  logic       in_ready;
  logic [7:0] data_out;
  logic       CRC_start;
  logic       CRC_blocksize;
  logic       CRC_end;
  logic       error;
  logic [1:0] fsm_state;

  crc_attach_bus dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .blocksize_sel (blocksize_sel),
    .in_ready      (in_ready),
    .data_out      (data_out),
    .CRC_start     (CRC_start),
    .CRC_blocksize (CRC_blocksize),
    .CRC_end       (CRC_end),
    .error         (error),
    .fsm_state     (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // One payload pattern: lane i carries a 1 at distance 0/1/2 from the end of
  // the payload when bit i of hot0/hot1/hot2 is set. x^24, x^25, x^26 mod P
  // give 864CFB, 8AD50D, 93E6E1.
  typedef struct packed {
    logic             bsel;
    logic [7:0]       hot0;
    logic [7:0]       hot1;
    logic [7:0]       hot2;
    logic [7:0][23:0] crc;
    logic [3:0]       gap;
  } vec_t;

  vec_t        vecs[5];
  logic [12:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic        last_bsz = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic rdy, input logic st, input logic en,
                                     input logic er, input logic bs, input logic [7:0] d);
    return {rdy, st, en, er, bs, d};
  endfunction

  function automatic logic [12:0] obs();
    return {in_ready, CRC_start, CRC_end, error, CRC_blocksize, data_out};
  endfunction

  function automatic logic [7:0] pword(input vec_t v, input int k, input int j);
    int e;
    e = k - 1 - j;
    return (e == 0 ? v.hot0 : 8'h00) | (e == 1 ? v.hot1 : 8'h00) | (e == 2 ? v.hot2 : 8'h00);
  endfunction

  // Driver: apply one cycle of inputs, then score the registered outputs.
  task automatic step(input logic [7:0] d, input logic dv, input logic bs,
                      input logic [12:0] exp, input string name);
    data_in       = d;
    data_valid    = dv;
    blocksize_sel = bs;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cyc++;
    chk(name, {19'd0, obs()}, {19'd0, exp_q.pop_front()});
  endtask

  task automatic idle(input int n, input logic bsz);
    for (int i = 0; i < n; i++)
      step(8'(i * 37), 1'b0, 1'($urandom_range(0, 1)), mk(1'b1, 1'b0, 1'b0, 1'b0, bsz, 8'h00), "idle");
  endtask

  // cut_kind: 0 = full block, 1 = drop data_valid at cut_at, 2 = reset at cut_at
  task automatic run_block(input vec_t v, input int cut_at, input int cut_kind);
    int               k;
    int               start_cyc;
    int               end_cyc;
    int               low_cnt;
    logic [7:0]       d;
    logic [7:0]       w;
    logic [7:0][23:0] cap;
    k         = v.bsel ? 6120 : 1032;
    start_cyc = 0;
    end_cyc   = 0;
    low_cnt   = 0;
    cap       = '0;
    for (int j = 0; j < k; j++) begin
      if (cut_kind == 1 && j == cut_at) begin
        step(8'h5A, 1'b0, v.bsel, mk(1'b1, 1'b0, 1'b0, 1'b1, v.bsel, 8'h00), "abort");
        return;
      end
      if (cut_kind == 2 && j == cut_at) begin
        #3;
        reset      = 1'b1;
        data_valid = 1'b0;
        #1;
        chk("reset_async_outputs", {19'd0, obs()}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_held_outputs", {19'd0, obs()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release_outputs", {19'd0, obs()}, {19'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00)});
        chk("reset_release_state", {30'd0, fsm_state}, 32'd0);
        return;
      end
      d = pword(v, k, j);
      // Toggle the size request mid-block; only the start value may count.
      step(d, 1'b1, (j == 0) ? v.bsel : ~v.bsel,
           mk(j != k - 1, j == 0, 1'b0, 1'b0, v.bsel, d), "payload");
      if (j == 0) start_cyc = cyc;
      if (!in_ready) low_cnt++;
    end
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) w[i] = v.crc[i][23 - n];
      step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           mk(n == 23, 1'b0, n == 23, 1'b0, v.bsel, w), "crc_word");
      for (int i = 0; i < 8; i++) cap[i] = {cap[i][22:0], data_out[i]};
      if (!in_ready) low_cnt++;
      if (CRC_end) end_cyc = cyc;
    end
    chk("crc_end_output_cycle", end_cyc - start_cyc + 1, k + 24);
    chk("in_ready_low_cycles", low_cnt, 24);
    for (int i = 0; i < 8; i++) chk($sformatf("lane%0d_crc", i), {8'd0, cap[i]}, {8'd0, v.crc[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '0; vecs[0].gap = 4'd3;
    vecs[1] = '0; vecs[1].gap = 4'd2;
    vecs[1].hot0 = 8'h01; vecs[1].crc[0] = 24'h864CFB;
    vecs[2] = '0; vecs[2].gap = 4'd0;
    vecs[2].hot0 = 8'h0C; vecs[2].hot1 = 8'h0A; vecs[2].hot2 = 8'h80;
    vecs[2].crc[1] = 24'h8AD50D; vecs[2].crc[2] = 24'h864CFB;
    vecs[2].crc[3] = 24'h0C99F6; vecs[2].crc[7] = 24'h93E6E1;
    vecs[3] = '0; vecs[3].gap = 4'd1; vecs[3].bsel = 1'b1;
    vecs[3].hot0 = 8'h80; vecs[3].hot1 = 8'h01;
    vecs[3].crc[7] = 24'h864CFB; vecs[3].crc[0] = 24'h8AD50D;
    vecs[4] = '0; vecs[4].gap = 4'd0;
    vecs[4].hot2 = 8'h01; vecs[4].hot0 = 8'h40;
    vecs[4].crc[0] = 24'h93E6E1; vecs[4].crc[6] = 24'h864CFB;

    // Reset
    reset         = 1'b1;
    data_in       = 8'h00;
    data_valid    = 1'b0;
    blocksize_sel = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, obs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_outputs", {19'd0, obs()}, {19'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00)});
    chk("post_reset_state", {30'd0, fsm_state}, 32'd0);

    // Table: blocks 1->2 and 3->4 run back-to-back
    for (int vi = 0; vi < 5; vi++) begin
      idle(int'(vecs[vi].gap), last_bsz);
      run_block(vecs[vi], -1, 0);
      last_bsz = vecs[vi].bsel;
    end

    // Payload underrun at word 500, then a fresh block
    idle(2, last_bsz);
    run_block(vecs[1], 500, 1);
    idle(2, 1'b0);
    run_block(vecs[1], -1, 0);

    // Asynchronous reset at payload word 300, then a full block
    idle(1, 1'b0);
    run_block(vecs[2], 300, 2);
    run_block(vecs[2], -1, 0);
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
